// File: rtl/fg_pkg.sv
// Shared definitions for the function-generator DDS path: waveform modes,
// configuration register selectors and reset constants.
package fg_pkg;

  typedef enum logic [1:0] {
    MODE_SAW    = 2'd0,
    MODE_TRI    = 2'd1,
    MODE_SQUARE = 2'd2,
    MODE_DC     = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    SEL_INC  = 2'd0,
    SEL_PSC  = 2'd1,
    SEL_MODE = 2'd2,
    SEL_CTRL = 2'd3
  } cfg_sel_e;

  localparam logic [7:0] DUTY_RST = 8'h80;
  localparam mode_e      MODE_RST = MODE_SAW;

  // A single channel still needs a one-bit select port.
  function automatic int chWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dds_channel.sv
// One DDS channel: shadow/active configuration, sample-tick prescaler,
// phase accumulator and waveform shaper with registered DAC code output.
module dds_channel
  import fg_pkg::*;
#(
  parameter int PHASE_W = 24,
  parameter int PSC_W   = 24,
  parameter int DAC_W   = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [1:0]       i_sel,
  input  logic [31:0]      i_data,
  input  logic             i_upd,
  output logic [DAC_W-1:0] o_code,
  output logic             o_valid,
  output logic             o_wrap
);

  logic [PHASE_W-1:0] r_shInc;
  logic [PSC_W-1:0]   r_shPsc;
  mode_e              r_shMode;
  logic [7:0]         r_shDuty;
  logic [DAC_W-1:0]   r_shLevel;
  logic               r_shEn;
  logic               r_shPrst;

  logic [PHASE_W-1:0] r_actInc;
  logic [PSC_W-1:0]   r_actPsc;
  mode_e              r_actMode;
  logic [7:0]         r_actDuty;
  logic [DAC_W-1:0]   r_actLevel;
  logic               r_actEn;

  logic [PHASE_W-1:0] r_phase;
  logic [PSC_W-1:0]   r_count;
  logic [DAC_W-1:0]   r_code;
  logic               r_valid;
  logic               r_wrap;

  logic [PHASE_W-1:0] w_nxInc;
  logic [PSC_W-1:0]   w_nxPsc;
  mode_e              w_nxMode;
  logic [7:0]         w_nxDuty;
  logic [DAC_W-1:0]   w_nxLevel;
  logic               w_nxEn;
  logic               w_nxPrst;

  logic               w_commitRst;
  logic               w_tick;
  logic [PHASE_W:0]   w_sum;
  logic [DAC_W-1:0]   w_p;
  logic [DAC_W-1:0]   w_pFold;
  logic [DAC_W-1:0]   w_shape;
  logic               w_unusedData;

  // Shadow contents as they will be after this edge, so a write landing in
  // the same cycle as a commit is carried straight into the active set.
  always_comb begin
    w_nxInc   = r_shInc;
    w_nxPsc   = r_shPsc;
    w_nxMode  = r_shMode;
    w_nxDuty  = r_shDuty;
    w_nxLevel = r_shLevel;
    w_nxEn    = r_shEn;
    w_nxPrst  = r_shPrst;
    if (i_we) begin
      case (cfg_sel_e'(i_sel))
        SEL_INC:  w_nxInc = i_data[PHASE_W-1:0];
        SEL_PSC:  w_nxPsc = i_data[PSC_W-1:0];
        SEL_MODE: begin
          w_nxMode  = mode_e'(i_data[1:0]);
          w_nxDuty  = i_data[15:8];
          w_nxLevel = i_data[16 +: DAC_W];
        end
        SEL_CTRL: begin
          w_nxEn   = i_data[0];
          w_nxPrst = i_data[1];
        end
        default: ;
      endcase
    end
  end

  assign w_unusedData = ^i_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shInc   <= '0;
      r_shPsc   <= '0;
      r_shMode  <= MODE_RST;
      r_shDuty  <= DUTY_RST;
      r_shLevel <= '0;
      r_shEn    <= 1'b0;
      r_shPrst  <= 1'b0;
    end else begin
      r_shInc   <= w_nxInc;
      r_shPsc   <= w_nxPsc;
      r_shMode  <= w_nxMode;
      r_shDuty  <= w_nxDuty;
      r_shLevel <= w_nxLevel;
      r_shEn    <= w_nxEn;
      r_shPrst  <= i_upd ? 1'b0 : w_nxPrst;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_actInc   <= '0;
      r_actPsc   <= '0;
      r_actMode  <= MODE_RST;
      r_actDuty  <= DUTY_RST;
      r_actLevel <= '0;
      r_actEn    <= 1'b0;
    end else if (i_upd) begin
      r_actInc   <= w_nxInc;
      r_actPsc   <= w_nxPsc;
      r_actMode  <= w_nxMode;
      r_actDuty  <= w_nxDuty;
      r_actLevel <= w_nxLevel;
      r_actEn    <= w_nxEn;
    end
  end

  assign w_commitRst = i_upd & w_nxPrst;
  assign w_tick      = r_actEn & (r_count == r_actPsc);
  assign w_sum       = {1'b0, r_phase} + {1'b0, r_actInc};

  // The shaper looks at the post-tick phase so the code leaves with its tick.
  assign w_p     = w_sum[PHASE_W-1 -: DAC_W];
  assign w_pFold = {w_p[DAC_W-2:0], 1'b0};

  always_comb begin
    w_shape = w_p;
    case (r_actMode)
      MODE_SAW:    w_shape = w_p;
      MODE_TRI:    w_shape = w_sum[PHASE_W-1] ? ~w_pFold : w_pFold;
      MODE_SQUARE: w_shape = (w_sum[PHASE_W-1 -: 8] < r_actDuty) ? '1 : '0;
      MODE_DC:     w_shape = r_actLevel;
      default:     w_shape = w_p;
    endcase
  end

  // A phase-reset commit wins over any tick from the outgoing configuration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= '0;
      r_count <= '0;
      r_code  <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
      if (w_commitRst) begin
        r_phase <= '0;
        r_count <= '0;
      end else if (r_actEn) begin
        if (w_tick) begin
          r_count <= '0;
          r_phase <= w_sum[PHASE_W-1:0];
          r_code  <= w_shape;
          r_valid <= 1'b1;
          r_wrap  <= w_sum[PHASE_W];
        end else begin
          r_count <= r_count + PSC_W'(1);
        end
      end
    end
  end

  assign o_code  = r_code;
  assign o_valid = r_valid;
  assign o_wrap  = r_wrap;

endmodule

// File: rtl/dds_channel_bank.sv
// N-channel DDS bank: routes configuration writes to the addressed channel
// and broadcasts the commit strobe to every channel.
module dds_channel_bank
  import fg_pkg::*;
#(
  parameter int N_CH    = 2,
  parameter int PHASE_W = 24,
  parameter int PSC_W   = 24,
  parameter int DAC_W   = 12,
  parameter int CH_W    = chWidth(N_CH)
) (
  input  logic                  sys_clk_i,
  input  logic                  sys_rst_i,
  input  logic                  cfg_we_i,
  input  logic [CH_W-1:0]       cfg_ch_i,
  input  logic [1:0]            cfg_sel_i,
  input  logic [31:0]           cfg_data_i,
  input  logic                  upd_i,
  output logic [N_CH*DAC_W-1:0] dds_o,
  output logic [N_CH-1:0]       dds_valid_o,
  output logic [N_CH-1:0]       wrap_o
);

  // Select values beyond the last channel match no instance and are dropped.
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic w_we;
    assign w_we = cfg_we_i && (cfg_ch_i == CH_W'(k));

    dds_channel #(
      .PHASE_W (PHASE_W),
      .PSC_W   (PSC_W),
      .DAC_W   (DAC_W)
    ) u_ch (
      .clk     (sys_clk_i),
      .rst     (sys_rst_i),
      .i_we    (w_we),
      .i_sel   (cfg_sel_i),
      .i_data  (cfg_data_i),
      .i_upd   (upd_i),
      .o_code  (dds_o[k*DAC_W +: DAC_W]),
      .o_valid (dds_valid_o[k]),
      .o_wrap  (wrap_o[k])
    );
  end

endmodule

// File: tb/tb_dds_channel_bank.sv
// Self-checking bench for dds_channel_bank: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_dds_channel_bank;
  import fg_pkg::*;

  localparam int N_CH    = 3;
  localparam int PHASE_W = 24;
  localparam int PSC_W   = 24;
  localparam int DAC_W   = 12;
  localparam int CH_W    = 2;
  localparam longint PH_MOD  = 64'd1 << PHASE_W;
  localparam longint PSC_MOD = 64'd1 << PSC_W;
  localparam longint D_MOD   = 64'd1 << DAC_W;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  cfgWe = 1'b0;
  logic [CH_W-1:0]       cfgCh = '0;
  logic [1:0]            cfgSel = '0;
  logic [31:0]           cfgData = '0;
  logic                  upd = 1'b0;
  logic [N_CH*DAC_W-1:0] ddsO;
  logic [N_CH-1:0]       validO;
  logic [N_CH-1:0]       wrapO;

  int testsRun = 0;
  int testsFailed = 0;

  dds_channel_bank #(
    .N_CH(N_CH), .PHASE_W(PHASE_W), .PSC_W(PSC_W), .DAC_W(DAC_W), .CH_W(CH_W)
  ) dut (
    .sys_clk_i   (clk),
    .sys_rst_i   (rst),
    .cfg_we_i    (cfgWe),
    .cfg_ch_i    (cfgCh),
    .cfg_sel_i   (cfgSel),
    .cfg_data_i  (cfgData),
    .upd_i       (upd),
    .dds_o       (ddsO),
    .dds_valid_o (validO),
    .wrap_o      (wrapO)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint inc;
    longint psc;
    longint mode;
    longint duty;
    longint level;
    bit     en;
    bit     prst;
  } cfg_t;

  cfg_t   mShadow[N_CH];
  cfg_t   mActive[N_CH];
  longint mPhase[N_CH];
  longint mCount[N_CH];
  longint mCode[N_CH];
  bit     mValid[N_CH];
  bit     mWrap[N_CH];

  typedef struct {
    bit          we;
    int          ch;
    int          sel;
    logic [31:0] data;
    bit          upd;
    bit          chk;
    int          chkCh;
    int          expCode;
    bit          expValid;
    bit          expWrap;
  } vec_t;

  vec_t vecs[$];

  task automatic modelReset();
    for (int k = 0; k < N_CH; k++) begin
      mShadow[k] = '{inc: 0, psc: 0, mode: 0, duty: 128, level: 0, en: 0, prst: 0};
      mActive[k] = mShadow[k];
      mPhase[k] = 0;
      mCount[k] = 0;
      mCode[k] = 0;
      mValid[k] = 0;
      mWrap[k] = 0;
    end
  endtask

  function automatic longint shapeRef(input cfg_t c, input longint phase);
    longint p;
    longint twice;
    p = phase / (PH_MOD / D_MOD);
    case (c.mode)
      0: return p;
      1: begin
        twice = (2 * p) % D_MOD;
        return (phase >= PH_MOD / 2) ? (D_MOD - 1 - twice) : twice;
      end
      2: return ((phase / (PH_MOD / 256)) < c.duty) ? D_MOD - 1 : 0;
      default: return c.level;
    endcase
  endfunction

  // One clock of the reference: the tick uses the configuration in force
  // before the edge; a commit installs the forwarded shadow afterwards.
  task automatic modelStep();
    cfg_t nx[N_CH];
    longint s;
    int ch;
    for (int k = 0; k < N_CH; k++) nx[k] = mShadow[k];
    ch = int'(cfgCh);
    if (cfgWe && ch < N_CH) begin
      case (int'(cfgSel))
        0: nx[ch].inc = longint'(cfgData) % PH_MOD;
        1: nx[ch].psc = longint'(cfgData) % PSC_MOD;
        2: begin
          nx[ch].mode  = longint'(cfgData) % 4;
          nx[ch].duty  = (longint'(cfgData) / 256) % 256;
          nx[ch].level = (longint'(cfgData) / 65536) % D_MOD;
        end
        default: begin
          nx[ch].en   = cfgData[0];
          nx[ch].prst = cfgData[1];
        end
      endcase
    end
    for (int k = 0; k < N_CH; k++) begin
      mValid[k] = 0;
      mWrap[k] = 0;
      if (upd && nx[k].prst) begin
        mPhase[k] = 0;
        mCount[k] = 0;
      end else if (mActive[k].en) begin
        if (mCount[k] == mActive[k].psc) begin
          s = mPhase[k] + mActive[k].inc;
          mWrap[k] = (s >= PH_MOD);
          mPhase[k] = s % PH_MOD;
          mCode[k] = shapeRef(mActive[k], mPhase[k]);
          mValid[k] = 1;
          mCount[k] = 0;
        end else begin
          mCount[k] = (mCount[k] + 1) % PSC_MOD;
        end
      end
    end
    if (upd) begin
      for (int k = 0; k < N_CH; k++) begin
        mActive[k] = nx[k];
        nx[k].prst = 0;
      end
    end
    for (int k = 0; k < N_CH; k++) mShadow[k] = nx[k];
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkModel(input string name);
    logic [N_CH*DAC_W-1:0] eDds;
    logic [N_CH-1:0] eV;
    logic [N_CH-1:0] eW;
    for (int k = 0; k < N_CH; k++) begin
      eDds[k*DAC_W +: DAC_W] = DAC_W'(mCode[k]);
      eV[k] = mValid[k];
      eW[k] = mWrap[k];
    end
    checkOutput(name, 64'({ddsO, validO, wrapO}), 64'({eDds, eV, eW}));
  endtask

  task automatic applyStimulus(input bit we, input int ch, input int sel, input logic [31:0] data, input bit u);
    cfgWe = we;
    cfgCh = CH_W'(ch);
    cfgSel = 2'(sel);
    cfgData = data;
    upd = u;
  endtask

  task automatic tick(input string name);
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkModel(name);
  endtask

  function automatic logic [63:0] chanCode(input int k);
    return 64'(ddsO[k*DAC_W +: DAC_W]);
  endfunction

  initial begin
    int triCodes[4];
    int nHigh;
    int nValid;
    vec_t v;

    triCodes[0] = 'h800;
    triCodes[1] = 'hFFF;
    triCodes[2] = 'h7FF;
    triCodes[3] = 'h000;

    // ch0 saw at one sample per clock, then ch1 triangle every 4th clock
    vecs.push_back('{1, 0, 0, 32'h0010_0000, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 0, 1, 32'h0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 0, 2, 32'h0000_8000, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 0, 3, 32'h1, 1, 1, 0, 0, 0, 0});
    for (int i = 1; i <= 16; i++)
      vecs.push_back('{0, 0, 0, 32'h0, 0, 1, 0, (i * 'h100) % 'h1000, 1, i == 16});
    vecs.push_back('{1, 1, 0, 32'h0040_0000, 0, 1, 0, 'h100, 1, 0});
    vecs.push_back('{1, 1, 1, 32'h3, 0, 1, 0, 'h200, 1, 0});
    vecs.push_back('{1, 1, 2, 32'h0000_8001, 0, 1, 0, 'h300, 1, 0});
    vecs.push_back('{1, 1, 3, 32'h1, 1, 1, 0, 'h400, 1, 0});
    for (int i = 1; i <= 16; i++)
      vecs.push_back('{0, 0, 0, 32'h0, 0, 1, 1,
                       (i < 4) ? 0 : triCodes[i / 4 - 1], (i % 4) == 0, i == 16});

    modelReset();
    #1 rst = 1'b1;
    #1 checkOutput("reset_outputs", 64'({ddsO, validO, wrapO}), 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      applyStimulus(v.we, v.ch, v.sel, v.data, v.upd);
      tick("vec_model");
      if (v.chk)
        checkOutput($sformatf("vec%0d_ch%0d", i, v.chkCh),
                    {chanCode(v.chkCh)[61:0], validO[v.chkCh], wrapO[v.chkCh]},
                    {62'(v.expCode), v.expValid, v.expWrap});
    end

    // Square wave on ch2: quarter duty, then zero duty
    applyStimulus(1, 2, 0, 32'h0001_0000, 0); tick("sq_cfg");
    applyStimulus(1, 2, 1, 32'h0, 0); tick("sq_cfg");
    applyStimulus(1, 2, 2, 32'h0000_4002, 0); tick("sq_cfg");
    applyStimulus(1, 2, 3, 32'h3, 1); tick("sq_cfg");
    applyStimulus(0, 0, 0, 32'h0, 0);
    nHigh = 0;
    nValid = 0;
    for (int i = 0; i < 256; i++) begin
      tick("sq_run");
      if (validO[2]) nValid++;
      if (validO[2] && chanCode(2) == 64'hFFF) nHigh++;
    end
    checkOutput("sq_duty40_high", 64'(nHigh), 64'd64);
    checkOutput("sq_duty40_valid", 64'(nValid), 64'd256);
    applyStimulus(1, 2, 2, 32'h0000_0002, 1); tick("sq_cfg");
    applyStimulus(0, 0, 0, 32'h0, 0);
    nHigh = 0;
    for (int i = 0; i < 256; i++) begin
      tick("sq0_run");
      if (chanCode(2) != 64'h0) nHigh++;
    end
    checkOutput("sq_duty0_high", 64'(nHigh), 64'd0);

    // ch0 phase reset, forwarded/unforwarded writes, ignored channel, disable
    applyStimulus(1, 0, 3, 32'h3, 1); tick("prst");
    checkOutput("prst_no_valid", 64'(validO[0]), 64'd0);
    applyStimulus(0, 0, 0, 32'h0, 0); tick("prst_next");
    checkOutput("prst_first", {chanCode(0)[62:0], validO[0]}, {63'h100, 1'b1});
    applyStimulus(1, 0, 0, 32'h0020_0000, 0); tick("inc_noupd");
    checkOutput("inc_noupd_a", chanCode(0), 64'h200);
    applyStimulus(0, 0, 0, 32'h0, 0); tick("inc_noupd");
    checkOutput("inc_noupd_b", chanCode(0), 64'h300);
    applyStimulus(1, 0, 0, 32'h0020_0000, 1); tick("inc_fwd");
    checkOutput("inc_fwd_old", chanCode(0), 64'h400);
    applyStimulus(0, 0, 0, 32'h0, 0); tick("inc_fwd");
    checkOutput("inc_fwd_new", chanCode(0), 64'h600);
    applyStimulus(1, 3, 0, 32'h0030_0000, 1); tick("bad_ch");
    checkOutput("bad_ch_a", chanCode(0), 64'h800);
    applyStimulus(0, 0, 0, 32'h0, 0); tick("bad_ch");
    checkOutput("bad_ch_b", chanCode(0), 64'hA00);
    applyStimulus(1, 0, 3, 32'h0, 1); tick("disable");
    checkOutput("disable_last", chanCode(0), 64'hC00);
    applyStimulus(0, 0, 0, 32'h0, 0);
    for (int i = 0; i < 3; i++) tick("disabled");
    checkOutput("disabled_hold", {chanCode(0)[62:0], validO[0]}, {63'hC00, 1'b0});

    // Randomized configuration traffic
    for (int i = 0; i < 1500; i++) begin
      int sel;
      logic [31:0] d;
      sel = int'($urandom_range(0, 3));
      case (sel)
        1:       d = $urandom_range(0, 5);
        3:       d = $urandom_range(0, 3);
        default: d = $urandom;
      endcase
      applyStimulus(($urandom % 3) == 0, int'($urandom_range(0, 3)), sel, d, ($urandom % 8) == 0);
      tick("rand");
    end

    // Asynchronous reset mid-run, then nothing until enabled and committed
    applyStimulus(0, 0, 0, 32'h0, 0);
    #2 rst = 1'b1;
    #1 checkOutput("midrun_reset", 64'({ddsO, validO, wrapO}), 64'h0);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick("post_reset");
    checkOutput("post_reset_quiet", 64'(validO), 64'h0);
    applyStimulus(1, 0, 3, 32'h1, 0); tick("en_noupd");
    applyStimulus(0, 0, 0, 32'h0, 0);
    for (int i = 0; i < 3; i++) tick("en_noupd");
    checkOutput("en_noupd_quiet", 64'(validO), 64'h0);
    applyStimulus(0, 0, 0, 32'h0, 1); tick("en_upd");
    applyStimulus(0, 0, 0, 32'h0, 0); tick("en_upd");
    checkOutput("en_upd_valid", 64'(validO), 64'h1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
